redun_mod_convert: RTL



---
 rtl/redun_conv_pkg.sv | 26 ++
 rtl/mod_cond_sub.sv | 15 +
 rtl/redun_mod_convert.sv | 127 ++++++++++++
 3 files changed

// File: rtl/redun_conv_pkg.sv
// Shared types and width formulas for the redundant-to-canonical converter.
package redun_conv_pkg;

    typedef enum logic [1:0] {IDLE, CARRY, REDUCE, DONE} state_t;

    function automatic int unsigned bitlen(input logic [63:0] x);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) r = i + 1;
        end
        return r;
    endfunction

    // Worst case: every coefficient at 2^COEF_BITS-1 still fits after propagation.
    function automatic int unsigned val_bits(input int unsigned i_word,
                                             input int unsigned word_bits,
                                             input int unsigned redun_bits);
        return i_word * word_bits + redun_bits + 1;
    endfunction

    function automatic int unsigned shifts(input int unsigned vbits, input int unsigned mbits);
        return vbits - mbits + 1;
    endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtract: returns val - t when val >= t, else val (unsigned).
module mod_cond_sub #(
    parameter int unsigned W = 42
) (
    input  logic [W-1:0] val_i,
    input  logic [W-1:0] t_i,
    output logic [W-1:0] res_o
);

    always_comb begin
        res_o = val_i;
        if (val_i >= t_i) res_o = val_i - t_i;
    end

endmodule

// File: rtl/redun_mod_convert.sv
// Word-serial carry propagation followed by fixed-length restoring reduction mod MODULUS.
module redun_mod_convert import redun_conv_pkg::*; #(
    parameter int unsigned WORD_BITS       = 8,
    parameter int unsigned NUM_WORDS       = 4,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 128,
    parameter int unsigned REDUN_WORD_BITS = 1,
    parameter int unsigned I_WORD          = NUM_WORDS + 1,
    parameter int unsigned COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int unsigned VAL_BITS        = val_bits(I_WORD, WORD_BITS, REDUN_WORD_BITS),
    parameter int unsigned MOD_BITS        = bitlen(64'(MODULUS)),
    parameter int unsigned SHIFTS          = shifts(VAL_BITS, MOD_BITS)
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_val,
    output logic                                o_rdy,
    input  logic [I_WORD-1:0][COEF_BITS-1:0]    i_dat,
    output logic                                o_val,
    input  logic                                i_rdy,
    output logic [NUM_WORDS*WORD_BITS-1:0]      o_dat
);

    localparam int unsigned CARRY_BITS = COEF_BITS + 1 - WORD_BITS;
    localparam int unsigned CNT_W      = (I_WORD > 1) ? $clog2(I_WORD) : 1;
    localparam int unsigned S_W        = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam int unsigned OUT_W      = NUM_WORDS * WORD_BITS;
    localparam logic [VAL_BITS-1:0] MOD_EXT = VAL_BITS'(MODULUS);

    state_t                             state_q, state_d;
    logic [I_WORD-1:0][COEF_BITS-1:0]   coef_q, coef_d;
    logic [CARRY_BITS-1:0]              carry_q, carry_d;
    logic [VAL_BITS-1:0]                val_q, val_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [S_W-1:0]                     s_q, s_d;
    logic                               rdy_q, oval_q;
    logic [OUT_W-1:0]                   dat_q, dat_d;

    logic [COEF_BITS:0]                 sum;
    logic [VAL_BITS-1:0]                t;
    logic [VAL_BITS-1:0]                sub_res;

    assign t = MOD_EXT << s_q;

    mod_cond_sub #(
        .W (VAL_BITS)
    ) u_mod_cond_sub (
        .val_i (val_q),
        .t_i   (t),
        .res_o (sub_res)
    );

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        carry_d = carry_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        dat_d   = dat_q;
        sum     = {1'b0, coef_q[cnt_q]} + {{WORD_BITS{1'b0}}, carry_q};
        unique case (state_q)
            IDLE: begin
                if (i_val && rdy_q) begin
                    coef_d  = i_dat;
                    carry_d = '0;
                    val_d   = '0;
                    cnt_d   = '0;
                    state_d = CARRY;
                end
            end
            CARRY: begin
                val_d[cnt_q*WORD_BITS +: WORD_BITS] = sum[WORD_BITS-1:0];
                carry_d = sum[COEF_BITS:WORD_BITS];
                if (cnt_q == CNT_W'(I_WORD - 1)) begin
                    val_d[VAL_BITS-1 -: CARRY_BITS] = sum[COEF_BITS:WORD_BITS];
                    s_d     = S_W'(SHIFTS - 1);
                    state_d = REDUCE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REDUCE: begin
                val_d = sub_res;
                if (s_q == '0) begin
                    dat_d   = sub_res[OUT_W-1:0];
                    state_d = DONE;
                end else begin
                    s_d = s_q - 1'b1;
                end
            end
            DONE: begin
                if (i_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            coef_q  <= '0;
            carry_q <= '0;
            val_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            rdy_q   <= 1'b0;
            oval_q  <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            coef_q  <= coef_d;
            carry_q <= carry_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rdy_q   <= (state_d == IDLE);
            oval_q  <= (state_d == DONE);
            dat_q   <= dat_d;
        end
    end

    assign o_rdy = rdy_q;
    assign o_val = oval_q;
    assign o_dat = dat_q;

endmodule
